// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection phase sequencer.
//   state_t : phase codes, also exported on the phase debug port
//   RED/YEL/GRN : one-hot lamp encodings, {red,yellow,green}
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        PED       = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: restartable tick counter measuring the time spent in a phase.
//   clk, reset_n : clock, asynchronous active-low reset
//   restart      : zero the count (asserted on the edge of a state change)
//   tick         : time-base strobe; the count only advances on tick
//   dur          : phase duration in ticks; 0 behaves as 1
//   saturate     : hold the count at dur-1 instead of wrapping
//   expired      : tick with count at dur-1 (last tick of the phase)
module phase_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          restart,
    input  logic          tick,
    input  logic [TW-1:0] dur,
    input  logic          saturate,
    output logic          expired
);

    logic [TW-1:0] count;
    logic [TW-1:0] last;

    assign last    = (dur == '0) ? '0 : dur - TW'(1);
    assign expired = tick && (count == last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (tick) begin
            if (count != last) begin
                count <= count + TW'(1);
            end else if (!saturate) begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: phase sequencer for an NS main / EW side intersection
// with a pedestrian crossing.
//   clk, reset_n : clock, asynchronous active-low reset
//   tick         : one-clk time-base strobe; all timing advances on tick
//   sensor_ew    : level, vehicle waiting on EW
//   ped_req      : pedestrian button, latched until PED is entered
//   ns_light     : NS lamps {red,yellow,green}, one-hot
//   ew_light     : EW lamps {red,yellow,green}, one-hot
//   walk         : pedestrian walk lamp
//   phase        : current state code
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned TW       = 8,
    parameter int unsigned GREEN_NS = 20,
    parameter int unsigned GREEN_EW = 10,
    parameter int unsigned YELLOW   = 3,
    parameter int unsigned ALL_RED  = 1,
    parameter int unsigned PED_WALK = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       sensor_ew,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [TW-1:0] DUR_NS  = TW'(GREEN_NS);
    localparam logic [TW-1:0] DUR_EW  = TW'(GREEN_EW);
    localparam logic [TW-1:0] DUR_Y   = TW'(YELLOW);
    localparam logic [TW-1:0] DUR_AR  = TW'(ALL_RED);
    localparam logic [TW-1:0] DUR_PED = TW'(PED_WALK);

    state_t        state;
    state_t        next_state;
    logic          ped_pending;
    logic [TW-1:0] dur;
    logic          expired;
    logic          restart;
    logic          saturate;

    // NS green saturates so that once the minimum has run out, every tick
    // reports expiry and the first tick with demand leaves the state.
    assign restart  = (next_state != state);
    assign saturate = (state == NS_GREEN);

    phase_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .restart  (restart),
        .tick     (tick),
        .dur      (dur),
        .saturate (saturate),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ALL_RED_B;
        end else begin
            state <= next_state;
        end
    end

    // A request arriving on the same edge that enters PED is served by that
    // PED phase, so the clear takes priority over the set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pending <= 1'b0;
        end else if (next_state == PED && state != PED) begin
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end
    end

    always_comb begin
        dur = DUR_AR;
        case (state)
            NS_GREEN:             dur = DUR_NS;
            NS_YELLOW, EW_YELLOW: dur = DUR_Y;
            EW_GREEN:             dur = DUR_EW;
            PED:                  dur = DUR_PED;
            default:              dur = DUR_AR;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            NS_GREEN:  if (expired && (sensor_ew || ped_pending)) next_state = NS_YELLOW;
            NS_YELLOW: if (expired) next_state = ALL_RED_A;
            ALL_RED_A: if (expired) next_state = ped_pending ? PED : EW_GREEN;
            EW_GREEN:  if (expired) next_state = EW_YELLOW;
            EW_YELLOW: if (expired) next_state = ALL_RED_B;
            ALL_RED_B: if (expired) next_state = NS_GREEN;
            PED:       if (expired) next_state = ALL_RED_B;
            default:   next_state = ALL_RED_B;
        endcase
    end

    always_comb begin
        ns_light = RED;
        ew_light = RED;
        walk     = 1'b0;
        case (state)
            NS_GREEN:  ns_light = GRN;
            NS_YELLOW: ns_light = YEL;
            EW_GREEN:  ew_light = GRN;
            EW_YELLOW: ew_light = YEL;
            PED:       walk     = 1'b1;
            default:   ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       sensor_ew;
    logic       ped_req;
    logic [2:0] ns_light, ew_light, phase;
    logic       walk;
    logic [2:0] ns0, ew0, phase0;
    logic       walk0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_light_fsm #(.TW(4), .GREEN_NS(4), .GREEN_EW(3), .YELLOW(2),
                        .ALL_RED(1), .PED_WALK(5)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .sensor_ew(sensor_ew),
        .ped_req(ped_req), .ns_light(ns_light), .ew_light(ew_light),
        .walk(walk), .phase(phase)
    );

    traffic_light_fsm #(.TW(4), .GREEN_NS(4), .GREEN_EW(3), .YELLOW(2),
                        .ALL_RED(0), .PED_WALK(5)) dut0 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .sensor_ew(sensor_ew),
        .ped_req(ped_req), .ns_light(ns0), .ew_light(ew0),
        .walk(walk0), .phase(phase0)
    );

    // Reference model: phase number, ticks elapsed in the phase, pending request.
    int m_ph;
    int m_el;
    bit m_pend;

    function automatic int m_dur(int ph);
        int d;
        case (ph)
            0:       d = 4;
            1, 4:    d = 2;
            3:       d = 3;
            6:       d = 5;
            default: d = 1;
        endcase
        d = d % 16;
        if (d == 0) d = 1;
        return d;
    endfunction

    function automatic logic [9:0] m_vec();
        logic [2:0] p, n, e;
        p = m_ph[2:0];
        n = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
        e = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
        return {p, n, e, (m_ph == 6)};
    endfunction

    function automatic int m_count();
        if (m_ph == 0 && m_el > m_dur(0) - 1) return m_dur(0) - 1;
        return m_el;
    endfunction

    task automatic model_reset();
        m_ph = 5; m_el = 0; m_pend = 0;
    endtask

    task automatic step(input logic t, input logic s, input logic p);
        int nxt;
        tick = t; sensor_ew = s; ped_req = p;
        @(posedge clk);
        nxt = m_ph;
        if (t) begin
            m_el++;
            if (m_el >= m_dur(m_ph)) begin
                case (m_ph)
                    0: if (s || m_pend) nxt = 1;
                    1: nxt = 2;
                    2: nxt = m_pend ? 6 : 3;
                    3: nxt = 4;
                    4: nxt = 5;
                    default: nxt = (m_ph == 5) ? 0 : 5;
                endcase
            end
        end
        if (p) m_pend = 1;
        if (nxt != m_ph) begin
            m_ph = nxt; m_el = 0;
            if (nxt == 6) m_pend = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        tick = 1; sensor_ew = 0; ped_req = 0; reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        tick = 1; sensor_ew = 0; ped_req = 0; reset_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({ns_light, ew_light, walk, phase} !== {3'b100, 3'b100, 1'b0, 3'd5}) begin
                bad++;
                $display("FAIL reset_hold: got ns=%b ew=%b walk=%b phase=%0d want 100/100/0/5",
                         ns_light, ew_light, walk, phase);
            end
        end
        reset_n = 1;
        model_reset();
        step(1, 0, 0);
        total++;
        if (phase !== 3'd0 || {phase, ns_light, ew_light, walk} !== m_vec()) begin
            bad++;
            $display("FAIL reset_release: got phase=%0d want 0", phase);
        end
    endtask

    task automatic test_no_demand();
        do_reset();
        for (int i = 0; i < 51; i++) begin
            step(1, 0, 0);
            total++;
            if (phase !== 3'd0 || ns_light !== 3'b001 || ew_light !== 3'b100) begin
                bad++;
                $display("FAIL no_demand: got phase=%0d ns=%b ew=%b want 0/001/100",
                         phase, ns_light, ew_light);
            end
        end
        total++;
        if (dut.u_timer.count !== 4'd3) begin
            bad++;
            $display("FAIL no_demand_count: got %0d want 3", dut.u_timer.count);
        end
    endtask

    task automatic test_ew_demand();
        int seq [13] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5};
        do_reset();
        for (int k = 1; k <= 39; k++) begin
            step(1, 1, 0);
            total++;
            if (phase !== 3'(seq[(k - 1) % 13]) || {phase, ns_light, ew_light, walk} !== m_vec()) begin
                bad++;
                $display("FAIL ew_seq tick %0d: got phase=%0d want %0d", k, phase, seq[(k - 1) % 13]);
            end
            total++;
            if (ns_light !== 3'b100 && ew_light !== 3'b100) begin
                bad++;
                $display("FAIL exclusion: got ns=%b ew=%b want one road red", ns_light, ew_light);
            end
            total++;
            if (dut.u_timer.count !== 4'(m_count())) begin
                bad++;
                $display("FAIL ew_count tick %0d: got %0d want %0d", k, dut.u_timer.count, m_count());
            end
        end
    endtask

    task automatic test_ped();
        int walk_clks = 0;
        bit saw_ew = 0;
        bit entered = 0;
        do_reset();
        step(1, 0, 0);
        for (int c = 1; c <= 120; c++) begin
            step((c % 4) == 0, 0, (c == 2));
            if (c == 2) begin
                total++;
                if (dut.ped_pending !== 1'b1) begin
                    bad++;
                    $display("FAIL ped_latch: got pending=%b want 1", dut.ped_pending);
                end
            end
            total++;
            if ({phase, ns_light, ew_light, walk} !== m_vec()) begin
                bad++;
                $display("FAIL ped_model clk %0d: got phase=%0d walk=%b want phase=%0d", c, phase, walk, m_ph);
            end
            if (walk) walk_clks++;
            if (phase == 3'd3) saw_ew = 1;
            if (phase == 3'd6 && !entered) begin
                entered = 1;
                total++;
                if (dut.ped_pending !== 1'b0) begin
                    bad++;
                    $display("FAIL ped_clear: got pending=%b want 0", dut.ped_pending);
                end
            end
        end
        total++;
        if (walk_clks != 20 || saw_ew || !entered) begin
            bad++;
            $display("FAIL ped_walk: got walk_clks=%0d ew_seen=%0d ped_seen=%0d want 20/0/1",
                     walk_clks, saw_ew, entered);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        while (phase != 3'd3 && n < 40) begin
            step(1, 1, 0);
            n++;
        end
        step(1, 1, 0);
        total++;
        if (phase !== 3'd3) begin
            bad++;
            $display("FAIL reset_mid_reach: got phase=%0d want 3", phase);
        end
        #2 reset_n = 0;
        #1;
        total++;
        if ({ns_light, ew_light, walk, phase} !== {3'b100, 3'b100, 1'b0, 3'd5}) begin
            bad++;
            $display("FAIL reset_mid_async: got ns=%b ew=%b walk=%b phase=%0d want 100/100/0/5",
                     ns_light, ew_light, walk, phase);
        end
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
        step(1, 1, 0);
        total++;
        if (phase !== 3'd0) begin
            bad++;
            $display("FAIL reset_mid_after: got phase=%0d want 0", phase);
        end
    endtask

    task automatic test_stall();
        logic [2:0] p0;
        logic [3:0] c0;
        int pre;
        do_reset();
        pre = $urandom_range(1, 20);
        for (int i = 0; i < pre; i++) step(1, 1, 0);
        p0 = phase;
        c0 = dut.u_timer.count;
        for (int i = 0; i < 30; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            total++;
            if (phase !== p0 || dut.u_timer.count !== c0 || {phase, ns_light, ew_light, walk} !== m_vec()) begin
                bad++;
                $display("FAIL stall: got phase=%0d count=%0d want phase=%0d count=%0d",
                         phase, dut.u_timer.count, p0, c0);
            end
        end
    endtask

    task automatic test_zero_dur();
        logic [2:0] prev;
        int run = 1;
        int runs = 0;
        do_reset();
        prev = phase0;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 0);
            if (phase0 == prev) begin
                run++;
            end else begin
                if (prev == 3'd2 || prev == 3'd5) begin
                    runs++;
                    total++;
                    if (run != 1) begin
                        bad++;
                        $display("FAIL zero_dur: phase %0d got %0d ticks want 1", prev, run);
                    end
                end
                prev = phase0;
                run = 1;
            end
        end
        total++;
        if (runs < 5) begin
            bad++;
            $display("FAIL zero_dur_runs: got %0d all-red phases want at least 5", runs);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            total++;
            if ({phase, ns_light, ew_light, walk} !== m_vec()) begin
                bad++;
                $display("FAIL random %0d: got phase=%0d ns=%b ew=%b walk=%b want phase=%0d",
                         i, phase, ns_light, ew_light, walk, m_ph);
            end
            total++;
            if (dut.ped_pending !== 1'(m_pend)) begin
                bad++;
                $display("FAIL random_pending %0d: got %b want %b", i, dut.ped_pending, m_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_demand();
        test_ew_demand();
        test_ped();
        test_reset_mid();
        test_stall();
        test_zero_dur();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
